seq_addsub_bcd_disp: RTL and testbench
======================================

// Module: seq_addsub_bcd_disp
// PURPOSE
//   Parametrised sequential add/subtract unit with on-board decimal display.
//   Latches two N-bit unsigned operands on a start request and computes A+B or A-B.
//   Converts the result magnitude to BCD with a one-bit-per-cycle double-dabble engine.
//   Drives DIGITS active-low 7-segment digits, a carry/borrow LED and a sign LED.
//   Intended as the switch/HEX demo core for DE-series boards; the top level maps SW/KEY/HEX/LEDR onto it.
// PARAMETERS
//   N        8  operand width in bits (2..16)
//   DIGITS   3  BCD digits shown; must satisfy 10**DIGITS > 2**(N+1)-1
//   BLANK_LZ 1  1 = blank leading zero digits (digit 0 always lit); 0 = show all digits
// PORTS
//   CLOCK_50  in   1          system clock, all state on rising edge
//   reset_n   in   1          asynchronous active-low reset
//   a         in   N          operand A, sampled only on the accepting edge
//   b         in   N          operand B, sampled only on the accepting edge
//   mode      in   1          0 = A+B, 1 = A-B; sampled with the operands
//   start     in   1          level request; accepted only in IDLE
//   busy      out  1          high in CALC, CONV and DONE
//   done      out  1          one-cycle pulse when new result outputs are valid
//   cout      out  1          add: carry out (sum bit N); sub: borrow (A<B)
//   neg       out  1          sub with A<B; always 0 for add
//   bcd       out  4*DIGITS   registered result magnitude in BCD, digit 0 = LSD
//   seg       out  7*DIGITS   active-low segments {g..a} per digit, digit 0 in [6:0]
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     state=IDLE; busy=done=cout=neg=0; bcd=0.
//     seg shows "0" on digit 0; other digits show "0" (BLANK_LZ=0) or blank (BLANK_LZ=1).
//   FSM states and transitions:
//     IDLE -> CALC when start=1; a, b and mode are registered on that edge.
//     CALC -> CONV after one cycle. The N+1-bit magnitude is loaded into the shift register:
//       add: {cout,sum} = a+b
//       sub: a>=b gives a-b with neg=0; a<b gives b-a with neg=1 and cout=1
//     CONV shifts once per cycle; before each shift, every BCD nibble >=5 gets +3.
//       The shift counter runs for exactly N+1 cycles, then the FSM goes to DONE.
//     DONE, on the entry edge: bcd, cout, neg and the seg registers update together; done=1 for this cycle.
//     DONE -> IDLE unconditionally.
//   Latency: done is high in the cycle after edge k+N+2, where k is the accepting edge.
//     With start held high, a new request is accepted every N+4 cycles.
//   Outputs bcd/seg/cout/neg hold the previous result until the next DONE. They never show partial conversions.
//   start while busy: ignored, not queued. Operand changes while busy have no effect.
//   Reset mid-operation: the FSM aborts immediately and all outputs take reset values. No done pulse is produced.
//   Widths: internal magnitude is N+1 bits; the BCD shift register is 4*DIGITS + N+1 bits. No truncation is permitted.
//   Leading-zero blanking: digit i>0 is blanked when it and every higher digit are 0.
//   Segment code: digits 0-9 use standard active-low patterns. Blank = 7'h7F. Codes 10-15 cannot occur; decode them as blank.
// STRUCTURE
//   Shared package: state encoding (IDLE, CALC, CONV, DONE) and the 7-segment pattern constants, including SEG_BLANK.
//   Sub-module bin2bcd_seq #(W=N+1, DIGITS): load/busy/valid handshake around the double-dabble shifter.
//   Reuse the existing disp7control decoder, one instance per digit, behind registered blanking muxes.
//   Top FSM, operand registers and add/sub datapath remain in this module.
// TESTING  (N=8, DIGITS=3, BLANK_LZ=1)
//   200+100, mode=0 -> done at edge k+10; bcd=12'h300, cout=1, neg=0.
//   5-9, mode=1 -> bcd=12'h004, neg=1, cout=1; digits 1 and 2 seg=7'h7F.
//   255+255 -> bcd=12'h510, cout=1. Then 0+0 -> bcd=0, seg = "  0", cout=0.
//   start held high for 40 cycles -> accepts at k, k+12, k+24, ...; exactly one done per accept.
//     Operands changed mid-run do not affect that run.
//   reset_n pulsed low during CONV -> outputs at reset values immediately.
//     No done follows; the next start completes normally.
//   Sweep all a,b in 0..255, both modes -> bcd, cout and neg match the reference model; busy is never high in IDLE.

Source files
------------

// File: rtl/seq_addsub_bcd_disp_pkg.sv
// Shared definitions for the add/subtract BCD display core: FSM state
// encoding and active-low 7-segment patterns ({g,f,e,d,c,b,a}, 0 = lit).
package seq_addsub_bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock for W cycles.
// load captures the binary value; valid is high during the cycle whose
// closing edge performs the final shift, and bcd then presents the value
// that shift produces so the caller can register it on that same edge.
module bin2bcd_seq #(
  parameter int W      = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4*DIGITS + W;
  localparam int CW = $clog2(W);

  logic [SW-1:0] sr;
  logic [SW-1:0] sr_adj;
  logic [SW-1:0] sr_next;
  logic [CW-1:0] cnt;
  logic          run;

  // Add-3 correction on every BCD nibble >= 5, then shift left by one.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[W+4*i +: 4] >= 4'd5) sr_adj[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
  end

  assign busy  = run;
  assign valid = run && (cnt == CW'(W-1));
  assign bcd   = sr_next[W +: 4*DIGITS];

  // Shift register and shift counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      sr  <= {{(4*DIGITS){1'b0}}, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr <= sr_next;
      if (cnt == CW'(W-1)) run <= 1'b0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp7control.sv
// Single-digit BCD to active-low 7-segment decoder. Codes 10-15 are not
// valid BCD and are shown as a blank digit.
module disp7control
  import seq_addsub_bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup from nibble to segment pattern.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_addsub_bcd_disp.sv
// Sequential add/subtract unit with decimal 7-segment display. Operands are
// latched on an accepted start, the N+1-bit magnitude is converted to BCD
// one bit per cycle, and all visible outputs update together on DONE entry.
module seq_addsub_bcd_disp
  import seq_addsub_bcd_disp_pkg::*;
#(
  parameter int N        = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic                mode,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                cout,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg
);

  state_t state, state_nxt;

  logic [N-1:0]        a_q, b_q;
  logic                mode_q;
  logic [N:0]          mag;
  logic                res_cout, res_neg;
  logic                conv_load, conv_busy, conv_valid;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [7*DIGITS-1:0] seg_raw, seg_next;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_CONV;
      ST_CONV: if (conv_valid) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign conv_load = (state == ST_CALC) && !conv_busy;

  // Operand capture on the accepting edge only.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  // Add/subtract datapath producing magnitude, carry/borrow and sign.
  always_comb begin
    mag      = {1'b0, a_q} + {1'b0, b_q};
    res_cout = mag[N];
    res_neg  = 1'b0;
    if (mode_q) begin
      if (a_q >= b_q) begin
        mag      = {1'b0, a_q} - {1'b0, b_q};
        res_cout = 1'b0;
      end else begin
        mag      = {1'b0, b_q} - {1'b0, a_q};
        res_cout = 1'b1;
        res_neg  = 1'b1;
      end
    end
  end

  bin2bcd_seq #(
    .W      (N + 1),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .load  (conv_load),
    .bin   (mag),
    .busy  (conv_busy),
    .valid (conv_valid),
    .bcd   (conv_bcd)
  );

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    disp7control u_disp (
      .digit (conv_bcd[4*g +: 4]),
      .seg   (seg_raw[7*g +: 7])
    );
  end

  // Leading-zero detection from the most significant digit downwards.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (conv_bcd[4*i +: 4] == 4'd0);
      blank[i]   = zero_above && (BLANK_LZ != 0);
    end
  end

  // Blanking mux in front of the segment registers.
  always_comb begin
    seg_next = seg_raw;
    for (int i = 0; i < DIGITS; i++) begin
      if (blank[i]) seg_next[7*i +: 7] = SEG_BLANK;
    end
  end

  // Visible result registers, all updated together on DONE entry.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bcd  <= '0;
      cout <= 1'b0;
      neg  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        seg[7*i +: 7] <= (i == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
      end
    end else if (state == ST_CONV && conv_valid) begin
      bcd  <= conv_bcd;
      cout <= res_cout;
      neg  <= res_neg;
      seg  <= seg_next;
    end
  end

endmodule

// File: tb/tb_seq_addsub_bcd_disp.sv
// Scoreboard bench for seq_addsub_bcd_disp (N=8, DIGITS=3, BLANK_LZ=1).
// The driver predicts accepts from the N+4 request cadence, pushes the
// arithmetic/decimal expectation, and a negedge monitor checks every done.
module tb_seq_addsub_bcd_disp;

  localparam int N = 8;
  localparam int DIGITS = 3;
  localparam int LAT = N + 2;   // done cycle offset from accepting edge
  localparam int PERIOD = N + 4;

  logic         clk, rst_n;
  logic [N-1:0] a, b;
  logic         mode, start;
  logic         busy, done, cout, neg;
  logic [11:0]  bcd;
  logic [20:0]  seg;

  seq_addsub_bcd_disp #(.N(N), .DIGITS(DIGITS), .BLANK_LZ(1)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cout     (cout),
    .neg      (neg),
    .bcd      (bcd),
    .seg      (seg)
  );

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        cout;
    logic        neg;
    int          acc;
  } exp_t;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [20:0] SEG_RST = {7'h7F, 7'h7F, 7'h40};

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   next_ok = 0;
  int   last_acc = -100;
  logic [11:0] held_bcd = '0;
  logic [20:0] held_seg = SEG_RST;
  logic        held_cout = 1'b0;
  logic        held_neg  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic and decimal digits.
  function automatic exp_t model(input int ia, input int ib, input bit im, input int acc);
    exp_t e;
    int r, m, d0, d1, d2;
    r  = im ? ia - ib : ia + ib;
    m  = (r < 0) ? -r : r;
    d0 = m % 10;
    d1 = (m / 10) % 10;
    d2 = m / 100;
    e.bcd  = 12'(d2 * 256 + d1 * 16 + d0);
    e.seg[6:0]   = pat[d0];
    e.seg[13:7]  = (d2 == 0 && d1 == 0) ? 7'h7F : pat[d1];
    e.seg[20:14] = (d2 == 0) ? 7'h7F : pat[d2];
    e.cout = im ? (ia < ib) : (r > 255);
    e.neg  = im && (r < 0);
    e.acc  = acc;
    return e;
  endfunction

  // Called at a negedge while start=1: predicts whether the coming edge accepts.
  task automatic maybe_accept();
    if (cyc + 1 >= next_ok) begin
      q.push_back(model(int'(a), int'(b), mode, cyc + 1));
      last_acc = cyc + 1;
      next_ok  = cyc + 1 + PERIOD;
    end
  endtask

  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic im);
    @(negedge clk);
    while (cyc + 1 < next_ok) @(negedge clk);
    a = ia; b = ib; mode = im; start = 1'b1;
    maybe_accept();
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); mode = 1'($urandom);
  endtask

  // Monitor: busy cadence, result on done, held outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("busy", 32'(busy), 32'(cyc >= last_acc && cyc <= last_acc + LAT));
      if (done) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
        end else begin
          e = q.pop_front();
          check("latency", 32'(cyc), 32'(e.acc + LAT));
          check("bcd",  32'(bcd),  32'(e.bcd));
          check("seg",  32'(seg),  32'(e.seg));
          check("cout", 32'(cout), 32'(e.cout));
          check("neg",  32'(neg),  32'(e.neg));
          held_bcd = e.bcd; held_seg = e.seg; held_cout = e.cout; held_neg = e.neg;
        end
      end else begin
        check("hold_bcd", 32'(bcd), 32'(held_bcd));
        check("hold_seg", 32'(seg), 32'(held_seg));
        check("hold_flags", 32'({cout, neg}), 32'({held_cout, held_neg}));
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; mode = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd",  32'(bcd),  32'h0);
    check("rst_seg",  32'(seg),  32'(SEG_RST));
    check("rst_flags", 32'({busy, done, cout, neg}), 32'h0);
    #2 rst_n = 1'b1;
    next_ok = cyc + 1;

    // Directed cases, including the sign/borrow and blanking boundaries.
    issue(8'd200, 8'd100, 1'b0);
    issue(8'd5,   8'd9,   1'b1);
    issue(8'd255, 8'd255, 1'b0);
    issue(8'd0,   8'd0,   1'b0);
    issue(8'd0,   8'd255, 1'b1);
    issue(8'd255, 8'd0,   1'b1);
    issue(8'd9,   8'd1,   1'b0);
    issue(8'd100, 8'd0,   1'b1);
    issue(8'd77,  8'd77,  1'b1);
    issue(8'd128, 8'd128, 1'b0);

    // start held high with operands changing every cycle.
    @(negedge clk);
    while (cyc + 1 < next_ok) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      a = N'($urandom); b = N'($urandom); mode = 1'($urandom); start = 1'b1;
      maybe_accept();
    end
    @(negedge clk);
    start = 1'b0;

    // Reset during conversion: outputs revert at once, no done follows.
    issue(8'd200, 8'd55, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_acc = -100;
    held_bcd = '0; held_seg = SEG_RST; held_cout = 1'b0; held_neg = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd), 32'h0);
    check("midrst_seg", 32'(seg), 32'(SEG_RST));
    check("midrst_flags", 32'({busy, done, cout, neg}), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    next_ok = cyc + 1;
    issue(8'd123, 8'd45, 1'b1);

    // Randomised operations.
    for (int i = 0; i < 250; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 4 * PERIOD && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
